// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: dcache (D) and icache (I) share one main-memory port, one transfer at a time.
// Define ROUND_ROBIN_EN to alternate grants on simultaneous requests; otherwise D wins ties.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [DATA_W-1:0] d_mem_writedata,
    output logic [DATA_W-1:0] d_mem_readdata,
    output logic              d_mem_busywait,
    input  logic [ADDR_W-1:0] i_mem_address,
    input  logic              i_mem_read,
    output logic [DATA_W-1:0] i_mem_readdata,
    output logic              i_mem_busywait,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait,
    output logic              timeout_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StGntD,
        StGntI
    } state_e;

    state_e              state_q, state_d;
    logic                last_gnt_i_q, last_gnt_i_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_writedata_q, mem_writedata_d;
    logic                timeout_err_q, timeout_err_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;

    logic dreq, ireq, done, pick_d;

    assign dreq = d_mem_read | d_mem_write;
    assign ireq = i_mem_read;
    // The issue cycle (cnt==0) never completes, so a stale low busywait is not taken as done.
    assign done = (state_q != StIdle) && (cnt_q != '0) && !mem_busywait;

`ifdef ROUND_ROBIN_EN
    assign pick_d = dreq & (~ireq | last_gnt_i_q);
`else
    assign pick_d = dreq;
`endif

    always_comb begin
        state_d         = state_q;
        last_gnt_i_d    = last_gnt_i_q;
        cnt_d           = cnt_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        timeout_err_d   = timeout_err_q;
        d_rdata_d       = d_rdata_q;
        i_rdata_d       = i_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (dreq || ireq) begin
                    cnt_d = '0;
                    if (pick_d) begin
                        state_d         = StGntD;
                        last_gnt_i_d    = 1'b0;
                        mem_address_d   = d_mem_address;
                        mem_writedata_d = d_mem_writedata;
                        mem_write_d     = d_mem_write;
                        mem_read_d      = d_mem_read & ~d_mem_write;
                    end else begin
                        state_d       = StGntI;
                        last_gnt_i_d  = 1'b1;
                        mem_address_d = i_mem_address;
                        mem_write_d   = 1'b0;
                        mem_read_d    = 1'b1;
                    end
                end
            end
            StGntD, StGntI: begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                if (cnt_q == CntMax && mem_busywait) begin
                    timeout_err_d = 1'b1;
                end
                if (done) begin
                    state_d     = StIdle;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    // Keep a copy of the delivered read block for when the port is not granted.
                    if (mem_read_q) begin
                        if (state_q == StGntD) begin
                            d_rdata_d = mem_readdata;
                        end else begin
                            i_rdata_d = mem_readdata;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= StIdle;
            last_gnt_i_q    <= 1'b1;
            cnt_q           <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            timeout_err_q   <= 1'b0;
            d_rdata_q       <= '0;
            i_rdata_q       <= '0;
        end else begin
            state_q         <= state_d;
            last_gnt_i_q    <= last_gnt_i_d;
            cnt_q           <= cnt_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            timeout_err_q   <= timeout_err_d;
            d_rdata_q       <= d_rdata_d;
            i_rdata_q       <= i_rdata_d;
        end
    end

    assign mem_address    = mem_address_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_writedata_q;
    assign timeout_err    = timeout_err_q;

    assign d_mem_busywait = dreq & ~((state_q == StGntD) & done);
    assign i_mem_busywait = ireq & ~((state_q == StGntI) & done);
    assign d_mem_readdata = (state_q == StGntD) ? mem_readdata : d_rdata_q;
    assign i_mem_readdata = (state_q == StGntI) ? mem_readdata : i_rdata_q;

endmodule
